// File: rtl/win3_pkg.sv
// Shared types and constants for the 3x3 window serializer: FSM states,
// window geometry and the emission-order lookup.
package win3_pkg;

    typedef enum logic [1:0] {
        ACCEPT,
        WAIT_DST,
        EMIT
    } state_t;

    localparam int WIN_SIZE   = 3;
    localparam int WIN_PIXELS = WIN_SIZE * WIN_SIZE;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } win_pos_t;

    // Column-major, oldest row first: idx 0..2 is column col-2, rows row-2..row.
    function automatic win_pos_t emit_pos(input logic [3:0] idx);
        win_pos_t p;
        p.col = 2'(idx / 4'd3);
        p.row = 2'(idx % 4'd3);
        return p;
    endfunction

endpackage

// File: rtl/line_buf.sv
// One line of pixel history: DEPTH x WIDTH RAM with a single shared address.
// The read is combinational, so a same-cycle write returns the previous contents.
module line_buf #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // NOTE: the array has no reset on purpose; the row/col gating keeps stale
    // contents from ever reaching the output, and a reset would block RAM mapping.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/win3_serializer.sv
// Builds a 3x3 neighbourhood per interior raster pixel and sends it as a 9-cycle
// burst on DO/DSO. Optional WIN_CNT window counter under `WIN3_STATS_EN`.
module win3_serializer
    import win3_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DI_VALID,
    output logic             DI_READY,
    input  logic             DO_READY,
    output logic [WIDTH-1:0] DO,
    output logic             DSO
`ifdef WIN3_STATS_EN
    ,
    output logic [15:0]      WIN_CNT
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t           state, state_nx;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [3:0]       k, k_nx;
    win_pos_t         pos_nx;
    logic [WIDTH-1:0] pix_nx;
    logic [WIDTH-1:0] lb0_rd, lb1_rd;
    logic [WIDTH-1:0] win [WIN_SIZE][WIN_SIZE];  // [row][col], index 0 = oldest
    logic             accept, col_last, row_last, win_ok, k_last;

    assign accept   = (state == ACCEPT) && DI_VALID;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));
    assign k_last   = (k == 4'(WIN_PIXELS - 1));
    assign DI_READY = (state == ACCEPT);

    // LB0 holds row-1, LB1 holds row-2; each accept pushes the column down one line.
    line_buf #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb0 (
        .clk    (CLK),
        .we     (accept),
        .addr   (col),
        .wr_data(DI),
        .rd_data(lb0_rd)
    );

    line_buf #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk    (CLK),
        .we     (accept),
        .addr   (col),
        .wr_data(lb0_rd),
        .rd_data(lb1_rd)
    );

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        k_nx     = '0;
        case (state)
            ACCEPT:   if (DI_VALID && win_ok) state_nx = WAIT_DST;
            WAIT_DST: if (DO_READY) state_nx = EMIT;
            EMIT: begin
                if (k_last) state_nx = ACCEPT;
                else        k_nx     = k + 4'd1;
            end
            default:  state_nx = ACCEPT;
        endcase
        pos_nx = emit_pos(k_nx);
        pix_nx = win[pos_nx.row][pos_nx.col];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ACCEPT;
            col   <= '0;
            row   <= '0;
            k     <= '0;
            DO    <= '0;
            DSO   <= 1'b0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            // DO/DSO are loaded for the cycle the FSM is about to spend in EMIT.
            if (state_nx == EMIT) begin
                DO  <= pix_nx;
                DSO <= 1'b1;
            end else begin
                DO  <= '0;
                DSO <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= DI;
        end
    end

`ifdef WIN3_STATS_EN
    // The finished frame's count stays readable until the next frame's first
    // pixel; only then does it restart from zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WIN_CNT <= '0;
        end else if (accept && (row == '0) && (col == '0)) begin
            WIN_CNT <= '0;
        end else if ((state == EMIT) && k_last && (WIN_CNT != 16'hFFFF)) begin
            WIN_CNT <= WIN_CNT + 16'd1;
        end
    end
`endif

endmodule
